// File: rtl/tc_sram_stream_adapter.sv
// Request-stream front-end for a fixed-latency single-port tc_sram.
// Read data lands in a credit-protected response FIFO, so the consumer can apply backpressure.
module tc_sram_stream_adapter #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned Latency   = 1,
    parameter int unsigned RspDepth  = 3,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int unsigned CntW = $clog2(RspDepth + 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(RspDepth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(RspDepth - 1);

    logic [CntW-1:0]      credit_q, credit_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [PtrW-1:0]      wptr_q, wptr_d;
    logic [PtrW-1:0]      rptr_q, rptr_d;
    logic [Latency-1:0]   infl_q, infl_d;
    logic [DataWidth-1:0] mem_q [RspDepth];

    logic fire, rd_fire, push, pop;

    // A credit reserves a FIFO slot for every read still travelling through the macro.
    assign req_ready_o  = rst_ni & (credit_q != '0);
    assign fire         = req_valid_i & req_ready_o;
    assign rd_fire      = fire & ~req_we_i;

    assign sram_req_o   = fire;
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_we_i ? req_be_i : '0;

    assign push        = infl_q[0];
    assign rsp_valid_o = (count_q != '0);
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign rsp_rdata_o = mem_q[rptr_q];

    always_comb begin
        credit_d = credit_q;
        count_d  = count_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        infl_d   = '0;

        unique case ({rd_fire, pop})
            2'b10:   credit_d = credit_q - CntW'(1);
            2'b01:   credit_d = credit_q + CntW'(1);
            default: credit_d = credit_q;
        endcase

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (push) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
        if (pop)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);

        for (int unsigned i = 0; i + 1 < Latency; i++) begin
            infl_d[i] = infl_q[i+1];
        end
        infl_d[Latency-1] = rd_fire;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            credit_q <= DepthC;
            count_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            infl_q   <= '0;
            for (int unsigned i = 0; i < RspDepth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            credit_q <= credit_d;
            count_q  <= count_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            infl_q   <= infl_d;
            if (push) mem_q[wptr_q] <= sram_rdata_i;
        end
    end

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && count_q == DepthC));
    a_credit_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rd_fire && !pop && credit_q == '0));
    a_credit_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && !rd_fire && credit_q == DepthC));
`endif

endmodule

// File: tb/tb_tc_sram_stream_adapter.sv
// Bench for tc_sram_stream_adapter with a behavioural latency-1 SRAM attached.
// Expected read data is queued when a read fires and checked when the response pops.
module tb_tc_sram_stream_adapter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_we, rsp_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          req_ready, rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          sram_req, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic [BW-1:0] sram_be;

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] smem [1024];

    always #5 clk = ~clk;

    tc_sram_stream_adapter dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_be_i     (req_be),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_be_o    (sram_be),
        .sram_rdata_i (sram_rdata)
    );

    // Behavioural single-port SRAM, read latency 1.
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (sram_be[b]) smem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
                end
            end else begin
                sram_rdata <= smem[sram_addr];
            end
        end
    end

    // Response scoreboard.
    always @(negedge clk) begin
        if (mon_en && rsp_valid && rsp_ready) begin
            logic [DW-1:0] e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rsp: got %h, none expected", rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                if (rsp_rdata !== e) begin
                    bad++;
                    $display("FAIL rsp_data: got %h, expected %h", rsp_rdata, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [BW-1:0] be);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
        @(negedge clk);
        total++;
        if (sram_req !== 1'b1 || sram_we !== 1'b1 || sram_addr !== a || sram_be !== be) begin
            bad++;
            $display("FAIL write_passthru: req=%b we=%b addr=%h be=%h, expected 1 1 %h %h",
                     sram_req, sram_we, sram_addr, sram_be, a, be);
        end
        step();
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d responses outstanding, expected 0", name, exp_q.size());
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0 || sram_req !== 1'b0) begin
            bad++;
            $display("FAIL ready_in_reset: ready=%b sram_req=%b, expected 0 0", req_ready, sram_req);
        end
        step();
        req_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || sram_req !== 1'b0 || rsp_rdata !== '0) begin
            bad++;
            $display("FAIL reset_idle: ready=%b valid=%b sram_req=%b rdata=%h, expected 1 0 0 0",
                     req_ready, rsp_valid, sram_req, rsp_rdata);
        end
        total++;
        if (dut.credit_q !== 2'd3) begin
            bad++;
            $display("FAIL reset_credit: got %0d, expected 3", dut.credit_q);
        end
        step();
        mon_en = 1'b1;
    endtask

    task automatic test_write_read();
        write_word(10'd5, 32'hDEADBEEF, 4'hF);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd5; req_be = 4'hF;
        @(negedge clk);
        total++;
        if (sram_req !== 1'b1 || sram_we !== 1'b0 || sram_be !== 4'h0) begin
            bad++;
            $display("FAIL read_passthru: req=%b we=%b be=%h, expected 1 0 0", sram_req, sram_we,
                     sram_be);
        end
        exp_q.push_back(32'hDEADBEEF);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || sram_req !== 1'b0) begin
            bad++;
            $display("FAIL rsp_latency_early: valid=%b sram_req=%b, expected 0 0", rsp_valid,
                     sram_req);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL rsp_latency: valid=%b two cycles after fire, expected 1", rsp_valid);
        end
        drain("write_read");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) write_word(AW'(i), 32'hA5000000 | DW'(i * 17), 4'hF);
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(i);
            @(negedge clk);
            total++;
            if (req_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready: cycle %0d ready=%b, expected 1", i, req_ready);
            end
            if (i >= 2) begin
                total++;
                if (rsp_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_rate: cycle %0d valid=%b, expected 1", i, rsp_valid);
                end
            end
            exp_q.push_back(32'hA5000000 | DW'(i * 17));
            step();
        end
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== (k < 2 ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL b2b_tail: cycle %0d valid=%b, expected %b", k, rsp_valid, k < 2);
            end
            step();
        end
        drain("b2b");
    endtask

    task automatic test_backpressure();
        int acc = 0;
        for (int i = 0; i < 8; i++) write_word(AW'(32 + i), 32'hC0DE0000 + DW'(i), 4'hF);
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(32 + acc);
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back(32'hC0DE0000 + DW'(acc));
                acc++;
            end
            step();
        end
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (acc != 3 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_accept: accepted=%0d ready=%b, expected 3 0", acc, req_ready);
        end
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hC0DE0000) begin
            bad++;
            $display("FAIL bp_hold: valid=%b rdata=%h, expected 1 c0de0000", rsp_valid, rsp_rdata);
        end
        step();
        rsp_ready = 1'b1;
        drain("bp");
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_resume: ready=%b valid=%b, expected 1 0", req_ready, rsp_valid);
        end
        step();
    endtask

    task automatic test_partial_write();
        write_word(10'd9, 32'h11223344, 4'hF);
        write_word(10'd9, 32'h0000AB00, 4'b0010);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL write_no_rsp: valid=%b, expected 0", rsp_valid);
            end
            step();
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd9;
        exp_q.push_back(32'h1122AB44);
        step();
        req_valid = 1'b0;
        drain("partial");
    endtask

    task automatic test_reset_midflight();
        mon_en = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(i);
            step();
        end
        req_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0 || dut.credit_q !== 2'd3) begin
                bad++;
                $display("FAIL midflight_reset: cycle %0d valid=%b credit=%0d, expected 0 3",
                         k, rsp_valid, dut.credit_q);
            end
            step();
        end
        mon_en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) smem[i] = '0;
        sram_rdata = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_partial_write();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
